ppu_raster: RTL and testbench

- Parametrised raster timing and status generator for the PPU. It supersedes the hard-wired 341x262 dot/line counters and VBL logic inside the PPU top.
- Generates dot/line position, render window, pixel-valid strobe and output coordinates, VBL flag and NMI.
- Adds behaviour the fixed block lacks: odd-frame dot skip, VBL read-race suppression, a programmable scanline-compare IRQ, and a frame-start pulse.
- Also serves PAL timing via parameters.

---
 rtl/ppu_pkg.sv | 50 +++++
 rtl/ppu_raster_if.sv | 43 ++++
 rtl/ppu_raster_cnt.sv | 75 +++++++
 rtl/ppu_raster.sv | 139 +++++++++++++
 tb/tb_ppu_raster.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// ppu_pkg
//   Shared constants for the PPU raster block and its neighbours.
//   - NTSC default geometry (341 dots x 262 lines, VBL on 241, pre-render 261,
//     odd-frame dot skip enabled).
//   - PAL geometry (312 lines, pre-render 311, no dot skip).
//   - Pixel pipeline delay between the dot counter and the pixel output.
//   - Status register bit positions, shared with the register block.
//   - Helper to check that a counter width can hold a given total.
package ppu_pkg;

    localparam int NTSC_HTOTAL   = 341;
    localparam int NTSC_VTOTAL   = 262;
    localparam int NTSC_HACTIVE  = 256;
    localparam int NTSC_VACTIVE  = 240;
    localparam int NTSC_VBL_LINE = 241;
    localparam int NTSC_PRE_LINE = 261;
    localparam int NTSC_SKIP_ODD = 1;

    localparam int PAL_HTOTAL    = 341;
    localparam int PAL_VTOTAL    = 312;
    localparam int PAL_VBL_LINE  = 241;
    localparam int PAL_PRE_LINE  = 311;
    localparam int PAL_SKIP_ODD  = 0;

    localparam int PIX_DELAY_DEF = 3;
    localparam int CMP_DOT_DEF   = 260;
    localparam int XW_DEF        = 9;
    localparam int YW_DEF        = 9;

    // Bit positions inside the CPU-visible status register.
    localparam int STAT_VBL_BIT  = 7;
    localparam int STAT_SPR0_BIT = 6;
    localparam int STAT_OVF_BIT  = 5;

    typedef enum logic [0:0] {
        VID_NTSC = 1'b0,
        VID_PAL  = 1'b1
    } video_std_e;

    // Lines per frame for a given video standard.
    function automatic int vtotal_for(video_std_e std);
        return (std == VID_PAL) ? PAL_VTOTAL : NTSC_VTOTAL;
    endfunction

    // True when a counter of 'width' bits can count 0..total-1.
    function automatic bit geom_fits(int total, int width);
        return (total >= 2) && (total <= (1 << width));
    endfunction

endpackage

// File: rtl/ppu_raster_if.sv
// ppu_raster_if
//   Bundle of every non-clock/reset signal of the raster generator.
//   master : the PPU side (drives tick, enables, CPU strobes, compare value,
//            consumes position, window, pixel and status outputs).
//   slave  : the raster generator itself.
interface ppu_raster_if
    import ppu_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF
);

    logic          tick;
    logic          render_en;
    logic          nmi_en;
    logic          rd_status;
    logic [YW-1:0] cmp_line;
    logic          cmp_en;
    logic          irq_ack;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          odd;
    logic          render;
    logic          vbl;
    logic          nmi;
    logic          irq;
    logic          pxvalid;
    logic [XW-1:0] outx;
    logic [YW-1:0] outy;
    logic          frame_start;

    modport master (
        output tick, render_en, nmi_en, rd_status, cmp_line, cmp_en, irq_ack,
        input  x, y, odd, render, vbl, nmi, irq, pxvalid, outx, outy, frame_start
    );

    modport slave (
        input  tick, render_en, nmi_en, rd_status, cmp_line, cmp_en, irq_ack,
        output x, y, odd, render, vbl, nmi, irq, pxvalid, outx, outy, frame_start
    );

endinterface

// File: rtl/ppu_raster_cnt.sv
// ppu_raster_cnt
//   Dot/line position counters with odd-frame tracking.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     tick           dot enable; nothing moves unless high
//     render_en      rendering enabled (qualifies the odd-frame dot skip)
//     x, y           current dot and line
//     odd            odd-frame flag, toggles at every frame wrap
//     frame_start    high during the tick that loads (0,0), by either the
//                    normal end-of-frame wrap or the odd-frame short line
module ppu_raster_cnt
    import ppu_pkg::*;
#(
    parameter int HTOTAL   = NTSC_HTOTAL,
    parameter int VTOTAL   = NTSC_VTOTAL,
    parameter int PRE_LINE = NTSC_PRE_LINE,
    parameter int SKIP_ODD = NTSC_SKIP_ODD,
    parameter int XW       = XW_DEF,
    parameter int YW       = YW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          render_en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          odd,
    output logic          frame_start
);

    localparam logic [XW-1:0] X_LAST = XW'(HTOTAL - 1);
    localparam logic [XW-1:0] X_SKIP = XW'(HTOTAL - 2);
    localparam logic [XW-1:0] X_INC  = XW'(1);
    localparam logic [YW-1:0] Y_LAST = YW'(VTOTAL - 1);
    localparam logic [YW-1:0] Y_PRE  = YW'(PRE_LINE);
    localparam logic [YW-1:0] Y_INC  = YW'(1);
    localparam logic          SKIP_EN = (SKIP_ODD != 0);

    logic line_end;
    logic frame_end;
    logic skip_now;

    // On an odd frame with rendering on, the pre-render line is one dot
    // short: the last dot is jumped over straight to (0,0).
    always_comb begin
        line_end    = 1'b0;
        frame_end   = 1'b0;
        skip_now    = 1'b0;
        frame_start = 1'b0;
        line_end    = (x == X_LAST);
        frame_end   = line_end && (y == Y_LAST);
        skip_now    = SKIP_EN && odd && render_en && (y == Y_PRE) && (x == X_SKIP);
        frame_start = tick && (frame_end || skip_now);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x   <= '0;
            y   <= '0;
            odd <= 1'b0;
        end else if (tick) begin
            if (frame_end || skip_now) begin
                x   <= '0;
                y   <= '0;
                odd <= ~odd;
            end else if (line_end) begin
                x <= '0;
                y <= y + Y_INC;
            end else begin
                x <= x + X_INC;
            end
        end
    end

endmodule

// File: rtl/ppu_raster.sv
// ppu_raster
//   Parametrised raster timing and status generator for the PPU.
//   Ports:
//     clk, reset_n   clock, asynchronous active-low reset
//     bus (slave)    tick, render_en, nmi_en, rd_status, cmp_line, cmp_en,
//                    irq_ack in; x, y, odd, render, vbl, nmi, irq, pxvalid,
//                    outx, outy, frame_start out
//   The counter sub-block owns position and frame tracking; this level holds
//   the VBL, read-race suppression and line-compare IRQ flags and decodes the
//   visible window into the pixel strobe and pixel coordinates.
module ppu_raster
    import ppu_pkg::*;
#(
    parameter int HTOTAL    = NTSC_HTOTAL,
    parameter int VTOTAL    = NTSC_VTOTAL,
    parameter int HACTIVE   = NTSC_HACTIVE,
    parameter int VACTIVE   = NTSC_VACTIVE,
    parameter int VBL_LINE  = NTSC_VBL_LINE,
    parameter int PRE_LINE  = NTSC_PRE_LINE,
    parameter int PIX_DELAY = PIX_DELAY_DEF,
    parameter int SKIP_ODD  = NTSC_SKIP_ODD,
    parameter int CMP_DOT   = CMP_DOT_DEF,
    parameter int XW        = XW_DEF,
    parameter int YW        = YW_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    ppu_raster_if.slave bus
);

    localparam int XW1 = XW + 1;
    localparam int YW1 = YW + 1;

    localparam logic [XW-1:0]  X_ONE     = XW'(1);
    localparam logic [XW-1:0]  X_CMP     = XW'(CMP_DOT);
    localparam logic [XW-1:0]  X_PIX     = XW'(PIX_DELAY);
    localparam logic [XW1-1:0] X_PIX_END = XW1'(PIX_DELAY + HACTIVE);
    localparam logic [YW-1:0]  Y_VBL     = YW'(VBL_LINE);
    localparam logic [YW-1:0]  Y_PRE     = YW'(PRE_LINE);
    localparam logic [YW1-1:0] Y_VACT    = YW1'(VACTIVE);

    logic [XW-1:0] x_cur;
    logic [YW-1:0] y_cur;
    logic          odd_cur;
    logic          fs_cur;

    logic vbl;
    logic suppress;
    logic irq;

    logic in_x_win;
    logic in_y_vis;
    logic vbl_set;
    logic vbl_clr;
    logic race_win;
    logic irq_set;

    ppu_raster_cnt #(
        .HTOTAL   (HTOTAL),
        .VTOTAL   (VTOTAL),
        .PRE_LINE (PRE_LINE),
        .SKIP_ODD (SKIP_ODD),
        .XW       (XW),
        .YW       (YW)
    ) u_cnt (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (bus.tick),
        .render_en   (bus.render_en),
        .x           (x_cur),
        .y           (y_cur),
        .odd         (odd_cur),
        .frame_start (fs_cur)
    );

    // Window decode and flag set/clear conditions. The horizontal and
    // vertical limits are compared one bit wider so a window that ends
    // exactly at the counter range still decodes correctly. A compare line
    // outside the frame can never equal y, so it never fires.
    always_comb begin
        in_x_win = 1'b0;
        in_y_vis = 1'b0;
        vbl_set  = 1'b0;
        vbl_clr  = 1'b0;
        race_win = 1'b0;
        irq_set  = 1'b0;
        in_x_win = (x_cur >= X_PIX) && ({1'b0, x_cur} < X_PIX_END);
        in_y_vis = ({1'b0, y_cur} < Y_VACT);
        vbl_set  = bus.tick && (x_cur == X_ONE) && (y_cur == Y_VBL) && !suppress;
        vbl_clr  = bus.tick && (x_cur == X_ONE) && (y_cur == Y_PRE);
        race_win = (y_cur == Y_VBL) && (x_cur <= X_ONE);
        irq_set  = bus.tick && bus.cmp_en && bus.render_en &&
                   (y_cur == bus.cmp_line) && (x_cur == X_CMP);
    end

    // Status flags. A CPU status read always clears vbl, even in the same
    // cycle as the set tick. A read just before or at the set tick also arms
    // suppress, so the flag stays low for the rest of that frame; suppress
    // is dropped together with vbl on the pre-render line. For the IRQ a
    // set in the same cycle as an acknowledge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vbl      <= 1'b0;
            suppress <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (bus.rd_status || vbl_clr) begin
                vbl <= 1'b0;
            end else if (vbl_set) begin
                vbl <= 1'b1;
            end

            if (vbl_clr) begin
                suppress <= 1'b0;
            end else if (bus.rd_status && race_win) begin
                suppress <= 1'b1;
            end

            if (irq_set) begin
                irq <= 1'b1;
            end else if (bus.irq_ack) begin
                irq <= 1'b0;
            end
        end
    end

    assign bus.x           = x_cur;
    assign bus.y           = y_cur;
    assign bus.odd         = odd_cur;
    assign bus.frame_start = fs_cur;
    assign bus.render      = bus.render_en && ((y_cur == Y_PRE) || in_y_vis);
    assign bus.vbl         = vbl;
    assign bus.nmi         = vbl && bus.nmi_en;
    assign bus.irq         = irq;
    assign bus.pxvalid     = bus.tick && in_x_win && in_y_vis;
    assign bus.outx        = x_cur - X_PIX;
    assign bus.outy        = y_cur;

endmodule

// File: tb/tb_ppu_raster.sv
// tb_ppu_raster
//   Self-checking bench for ppu_raster. Two instances share clock and reset:
//   an NTSC-shaped one (odd-frame skip on) and a PAL-shaped one (taller frame,
//   no skip). Both use a scaled-down geometry so whole frames stay short.
module tb_ppu_raster;
    import ppu_pkg::*;

    localparam int XW    = 5;
    localparam int YW    = 5;
    localparam int HT    = 24;
    localparam int HA    = 16;
    localparam int VA    = 12;
    localparam int VBLL  = 13;
    localparam int PD    = PIX_DELAY_DEF;
    localparam int CDOT  = 18;
    localparam int N_VT  = 20;
    localparam int N_PRE = 19;
    localparam int P_VT  = 25;
    localparam int P_PRE = 24;
    localparam int CLINE = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ppu_raster_if #(.XW(XW), .YW(YW)) bn ();
    ppu_raster_if #(.XW(XW), .YW(YW)) bp ();

    ppu_raster #(
        .HTOTAL(HT), .VTOTAL(N_VT), .HACTIVE(HA), .VACTIVE(VA),
        .VBL_LINE(VBLL), .PRE_LINE(N_PRE), .PIX_DELAY(PD), .SKIP_ODD(1),
        .CMP_DOT(CDOT), .XW(XW), .YW(YW)
    ) dut_ntsc (
        .clk(clk), .reset_n(reset_n), .bus(bn)
    );

    ppu_raster #(
        .HTOTAL(HT), .VTOTAL(P_VT), .HACTIVE(HA), .VACTIVE(VA),
        .VBL_LINE(VBLL), .PRE_LINE(P_PRE), .PIX_DELAY(PD), .SKIP_ODD(0),
        .CMP_DOT(CDOT), .XW(XW), .YW(YW)
    ) dut_pal (
        .clk(clk), .reset_n(reset_n), .bus(bp)
    );

    int tests_run = 0;
    int tests_failed = 0;

    int                  len_q[$];
    bit                  odd_q[$];
    logic [XW+YW-1:0]    pix_q[$];
    logic [XW+YW-1:0]    irq_q[$];

    // Reject geometries the design does not support before any stimulus.
    function automatic bit params_ok();
        return geom_fits(HT, XW) && geom_fits(N_VT, YW) && geom_fits(P_VT, YW) &&
               (PD + HA <= HT) && (VA < VBLL) && (VBLL < N_PRE) &&
               (N_PRE < N_VT) && (P_PRE < P_VT) && (CDOT < HT - 1);
    endfunction

    task automatic test_reset();
        bn.tick = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({bn.x, bn.y, bn.odd, bn.vbl, bn.irq, bn.nmi, bn.frame_start} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got x=%0d y=%0d odd=%0d vbl=%0d irq=%0d nmi=%0d fs=%0d, expected all 0",
                     bn.x, bn.y, bn.odd, bn.vbl, bn.irq, bn.nmi, bn.frame_start);
        end
        bn.tick = 1'b0;
        reset_n = 1'b1;
        bn.tick = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bn.tick = 1'b0;
        tests_run++;
        if (int'(bn.x) != 5 || int'(bn.y) != 0) begin
            tests_failed++;
            $display("[TB] FAIL count_after_reset: got (%0d,%0d), expected (5,0)", bn.x, bn.y);
        end
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if (int'(bn.x) != 0 || int'(bn.y) != 0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got (%0d,%0d), expected (0,0)", bn.x, bn.y);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        bn.tick = 1'b1;
        @(posedge clk);
        #1 bn.tick = 1'b0;
        tests_run++;
        if (int'(bn.x) != 1 || int'(bn.y) != 0) begin
            tests_failed++;
            $display("[TB] FAIL first_tick_after_reset: got (%0d,%0d), expected (1,0)", bn.x, bn.y);
        end
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
    endtask

    // Ticks the NTSC instance for nframes frames, checking each frame length
    // and the odd flag against the queued expectations.
    task automatic run_frames(input int nframes, input int budget,
                              output int vis_even, output int vis_odd);
        int cnt;
        int seen;
        int cyc;
        int exp_len;
        bit exp_odd;
        logic fs;
        cnt = 0; seen = 0; cyc = 0; vis_even = 0; vis_odd = 0;
        bn.tick = 1'b1;
        while (seen < nframes && cyc < budget) begin
            @(negedge clk);
            cnt++;
            cyc++;
            if (int'(bn.x) == HT - 1 && int'(bn.y) == N_PRE) begin
                if (bn.odd) vis_odd++;
                else        vis_even++;
            end
            fs = bn.frame_start;
            @(posedge clk);
            #1;
            if (fs && len_q.size() > 0) begin
                exp_len = len_q.pop_front();
                exp_odd = odd_q.pop_front();
                tests_run++;
                if (cnt != exp_len) begin
                    tests_failed++;
                    $display("[TB] FAIL frame_len: got %0d ticks, expected %0d", cnt, exp_len);
                end
                tests_run++;
                if (bn.odd !== exp_odd || int'(bn.x) != 0 || int'(bn.y) != 0) begin
                    tests_failed++;
                    $display("[TB] FAIL frame_wrap: got odd=%0d at (%0d,%0d), expected odd=%0d at (0,0)",
                             bn.odd, bn.x, bn.y, exp_odd);
                end
                cnt = 0;
                seen++;
            end
        end
        bn.tick = 1'b0;
        tests_run++;
        if (seen != nframes) begin
            tests_failed++;
            $display("[TB] FAIL frame_timeout: got %0d frames, expected %0d", seen, nframes);
        end
    endtask

    // Ticks until the NTSC instance sits at (tx,ty), leaving tick low.
    task automatic advance_to(input int tx, input int ty, input int budget);
        int cyc;
        cyc = 0;
        while (!(int'(bn.x) == tx && int'(bn.y) == ty) && cyc < budget) begin
            bn.tick = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        bn.tick = 1'b0;
        tests_run++;
        if (int'(bn.x) != tx || int'(bn.y) != ty) begin
            tests_failed++;
            $display("[TB] FAIL advance_timeout: got (%0d,%0d), expected (%0d,%0d)", bn.x, bn.y, tx, ty);
        end
    endtask

    task automatic test_frames_no_render();
        int ve;
        int vo;
        bn.render_en = 1'b0;
        len_q.push_back(HT * N_VT); odd_q.push_back(1'b1);
        len_q.push_back(HT * N_VT); odd_q.push_back(1'b0);
        run_frames(2, 3 * HT * N_VT, ve, vo);
    endtask

    task automatic test_odd_skip();
        int ve;
        int vo;
        bn.render_en = 1'b1;
        len_q.push_back(HT * N_VT);     odd_q.push_back(1'b1);
        len_q.push_back(HT * N_VT - 1); odd_q.push_back(1'b0);
        run_frames(2, 3 * HT * N_VT, ve, vo);
        tests_run++;
        if (vo != 0 || ve != 1) begin
            tests_failed++;
            $display("[TB] FAIL skip_dot_visits: got odd=%0d even=%0d, expected odd=0 even=1", vo, ve);
        end
        bn.render_en = 1'b0;
    endtask

    task automatic test_vbl_nmi();
        advance_to(1, VBLL, 2 * HT * N_VT);
        tests_run++;
        if (bn.vbl !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL vbl_before_set: got %0d, expected 0", bn.vbl);
        end
        bn.nmi_en = 1'b0;
        bn.tick = 1'b1;
        @(posedge clk);
        #1 bn.tick = 1'b0;
        tests_run++;
        if ({bn.vbl, bn.nmi} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL vbl_set: got vbl=%0d nmi=%0d, expected vbl=1 nmi=0", bn.vbl, bn.nmi);
        end
        bn.nmi_en = 1'b1;
        #1;
        tests_run++;
        if (bn.nmi !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL nmi_enable_late: got %0d, expected 1", bn.nmi);
        end
        bn.nmi_en = 1'b0;
        bn.rd_status = 1'b1;
        @(posedge clk);
        #1 bn.rd_status = 1'b0;
        tests_run++;
        if (bn.vbl !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL vbl_read_clear: got %0d, expected 0", bn.vbl);
        end
    endtask

    task automatic test_read_race();
        int bad;
        int cyc;
        advance_to(0, VBLL, 2 * HT * N_VT);
        bn.rd_status = 1'b1;
        bn.tick = 1'b1;
        @(posedge clk);
        #1;
        bn.rd_status = 1'b0;
        bn.nmi_en = 1'b1;
        bad = 0;
        cyc = 0;
        while (!(int'(bn.x) == 1 && int'(bn.y) == N_PRE) && cyc < 2 * HT * N_VT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bn.vbl || bn.nmi) bad++;
        end
        bn.tick = 1'b0;
        tests_run++;
        if (bad != 0 || int'(bn.y) != N_PRE) begin
            tests_failed++;
            $display("[TB] FAIL race_suppress: got %0d cycles with vbl/nmi high, ended line %0d, expected 0 at line %0d",
                     bad, bn.y, N_PRE);
        end
        advance_to(2, VBLL, 2 * HT * N_VT);
        tests_run++;
        if ({bn.vbl, bn.nmi} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL vbl_next_frame: got vbl=%0d nmi=%0d, expected 1 1", bn.vbl, bn.nmi);
        end
        bn.rd_status = 1'b1;
        @(posedge clk);
        #1 bn.rd_status = 1'b0;
        advance_to(1, VBLL, 2 * HT * N_VT);
        bn.tick = 1'b1;
        bn.rd_status = 1'b1;
        @(posedge clk);
        #1;
        bn.tick = 1'b0;
        bn.rd_status = 1'b0;
        advance_to(6, VBLL, HT);
        tests_run++;
        if (bn.vbl !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL race_same_cycle: got vbl=%0d, expected 0", bn.vbl);
        end
        bn.nmi_en = 1'b0;
    endtask

    task automatic test_irq();
        logic [XW-1:0]    px;
        logic [YW-1:0]    py;
        logic [XW+YW-1:0] exp_pos;
        logic             prev;
        bit               rose;
        int               cyc;
        int               fires;
        bn.render_en = 1'b1;
        bn.cmp_en = 1'b1;
        bn.cmp_line = YW'(CLINE);
        tests_run++;
        if (bn.irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_idle: got %0d, expected 0", bn.irq);
        end
        irq_q.push_back({XW'(CDOT), YW'(CLINE)});
        prev = bn.irq;
        rose = 1'b0;
        cyc = 0;
        bn.tick = 1'b1;
        while (!rose && cyc < 2 * HT * N_VT) begin
            @(negedge clk);
            px = bn.x;
            py = bn.y;
            @(posedge clk);
            #1;
            cyc++;
            if (bn.irq && !prev) begin
                rose = 1'b1;
                exp_pos = irq_q.pop_front();
                tests_run++;
                if ({px, py} !== exp_pos) begin
                    tests_failed++;
                    $display("[TB] FAIL irq_rise_pos: got (%0d,%0d), expected (%0d,%0d)",
                             px, py, exp_pos[XW+YW-1:YW], exp_pos[YW-1:0]);
                end
            end
            prev = bn.irq;
        end
        bn.tick = 1'b0;
        tests_run++;
        if (!rose) begin
            tests_failed++;
            $display("[TB] FAIL irq_rise_timeout: got no rise, expected one");
        end
        advance_to(0, 1, 2 * HT * N_VT);
        tests_run++;
        if (bn.irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL irq_hold_frame: got %0d, expected 1", bn.irq);
        end
        bn.irq_ack = 1'b1;
        @(posedge clk);
        #1 bn.irq_ack = 1'b0;
        tests_run++;
        if (bn.irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_ack: got %0d, expected 0", bn.irq);
        end
        advance_to(CDOT, CLINE, 2 * HT * N_VT);
        bn.tick = 1'b1;
        bn.irq_ack = 1'b1;
        @(posedge clk);
        #1;
        bn.tick = 1'b0;
        bn.irq_ack = 1'b0;
        tests_run++;
        if (bn.irq !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL irq_set_beats_ack: got %0d, expected 1", bn.irq);
        end
        bn.irq_ack = 1'b1;
        @(posedge clk);
        #1 bn.irq_ack = 1'b0;
        tests_run++;
        if (bn.irq !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL irq_late_ack: got %0d, expected 0", bn.irq);
        end
        bn.render_en = 1'b0;
        fires = 0;
        bn.tick = 1'b1;
        for (int i = 0; i < HT * N_VT; i++) begin
            @(posedge clk);
            #1;
            if (bn.irq) fires++;
        end
        tests_run++;
        if (fires != 0) begin
            tests_failed++;
            $display("[TB] FAIL irq_render_gate: got %0d cycles high, expected 0", fires);
        end
        bn.render_en = 1'b1;
        bn.cmp_line = YW'(N_VT);
        fires = 0;
        for (int i = 0; i < HT * N_VT; i++) begin
            @(posedge clk);
            #1;
            if (bn.irq) fires++;
        end
        bn.tick = 1'b0;
        tests_run++;
        if (fires != 0) begin
            tests_failed++;
            $display("[TB] FAIL irq_line_out_of_range: got %0d cycles high, expected 0", fires);
        end
        bn.cmp_en = 1'b0;
        bn.render_en = 1'b0;
    endtask

    task automatic test_pal_pixels();
        int cnt;
        int seen;
        int cyc;
        int pix_cnt;
        int rmis;
        int exp_len;
        logic fs;
        logic exp_r;
        logic [XW+YW-1:0] exp_pix;
        for (int f = 0; f < 2; f++) begin
            len_q.push_back(HT * P_VT);
            for (int oy = 0; oy < VA; oy++)
                for (int ox = 0; ox < HA; ox++)
                    pix_q.push_back({XW'(ox), YW'(oy)});
        end
        cnt = 0; seen = 0; cyc = 0; pix_cnt = 0; rmis = 0;
        bp.render_en = 1'b1;
        bp.tick = 1'b1;
        while (seen < 2 && cyc < 3 * HT * P_VT) begin
            @(negedge clk);
            cnt++;
            cyc++;
            exp_r = (int'(bp.y) == P_PRE) || (int'(bp.y) < VA);
            if (bp.render !== exp_r) rmis++;
            if (bp.pxvalid) begin
                if (pix_cnt == 0) begin
                    tests_run++;
                    if (int'(bp.x) != PD || int'(bp.outx) != 0 || int'(bp.outy) != 0) begin
                        tests_failed++;
                        $display("[TB] FAIL first_pixel: got x=%0d outx=%0d outy=%0d, expected x=%0d outx=0 outy=0",
                                 bp.x, bp.outx, bp.outy, PD);
                    end
                end
                exp_pix = (pix_q.size() > 0) ? pix_q.pop_front() : '1;
                tests_run++;
                if ({bp.outx, bp.outy} !== exp_pix) begin
                    tests_failed++;
                    $display("[TB] FAIL pixel_coord: got (%0d,%0d), expected (%0d,%0d)",
                             bp.outx, bp.outy, exp_pix[XW+YW-1:YW], exp_pix[YW-1:0]);
                end
                pix_cnt++;
            end
            fs = bp.frame_start;
            @(posedge clk);
            #1;
            if (fs && len_q.size() > 0) begin
                exp_len = len_q.pop_front();
                tests_run++;
                if (cnt != exp_len || pix_cnt != HA * VA) begin
                    tests_failed++;
                    $display("[TB] FAIL pal_frame: got %0d ticks %0d pixels, expected %0d ticks %0d pixels",
                             cnt, pix_cnt, exp_len, HA * VA);
                end
                cnt = 0;
                pix_cnt = 0;
                seen++;
            end
        end
        bp.tick = 1'b0;
        tests_run++;
        if (seen != 2 || pix_q.size() != 0 || rmis != 0) begin
            tests_failed++;
            $display("[TB] FAIL pal_summary: got frames=%0d pixels_left=%0d render_errs=%0d, expected 2 0 0",
                     seen, pix_q.size(), rmis);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bn.tick = 1'b0; bn.render_en = 1'b0; bn.nmi_en = 1'b0; bn.rd_status = 1'b0;
        bn.cmp_line = '0; bn.cmp_en = 1'b0; bn.irq_ack = 1'b0;
        bp.tick = 1'b0; bp.render_en = 1'b0; bp.nmi_en = 1'b0; bp.rd_status = 1'b0;
        bp.cmp_line = '0; bp.cmp_en = 1'b0; bp.irq_ack = 1'b0;
        if (!params_ok()) begin
            $display("[TB] FAIL param_constraints: geometry outside supported range");
            $fatal(1, "[TB] bad parameters");
        end
        test_reset();
        test_frames_no_render();
        test_odd_skip();
        test_vbl_nmi();
        test_read_race();
        test_irq();
        test_pal_pixels();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
